exec_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the execute datapath (register file + ALU control + ALU) one instruction at a time. It accepts 32-bit RV32I instructions over a valid/ready handshake, decodes them, and drives the datapath control inputs: we, alu_op, alu_src, rs1/rs2/rd, imm, funct3, funct7_5. It samples the ALU zero flag to resolve BEQ/BNE and owns the program counter.

---
 rtl/exec_ctrl_pkg.sv | 41 ++++
 rtl/exec_sequencer_imm_gen.sv | 21 ++
 rtl/exec_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared opcode constants, ALUOp encodings, sequencer state
// enum and the instruction classifier used by exec_sequencer.
package exec_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_RETIRE,
        ST_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_I,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_e;

    // Only BEQ (000) and BNE (001) are supported branches; everything else traps.
    function automatic instr_class_e classify(input logic [31:0] word);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        case (word[6:0])
            OP_R:      cls = CLS_R;
            OP_IMM:    cls = CLS_I;
            OP_BRANCH: cls = (word[14:13] == 2'b00) ? CLS_BRANCH : CLS_ILLEGAL;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/exec_sequencer_imm_gen.sv
// imm_gen: combinational immediate extraction with sign extension.
// I-type for OP-IMM, B-type for branches, zero for everything else.
module imm_gen
    import exec_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    // Select the immediate layout from the opcode; B-type bit 0 is always zero.
    always_comb begin
        imm_o = '0;
        case (instr_i[6:0])
            OP_IMM:    imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_BRANCH: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            default:   imm_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the execute datapath.
// One instruction is in flight at a time: IDLE -> DECODE -> EXEC -> RETIRE,
// or IDLE -> DECODE -> TRAP for unsupported encodings.
// Optional macro PERF_CNT_EN adds cycle_cnt and instret_cnt outputs.
module exec_sequencer
    import exec_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        we,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_e       state_q;
    logic [31:0]  instrWord_q;
    logic         ready_q;
    logic         we_q;
    logic [1:0]   aluOp_q;
    logic         aluSrc_q;
    logic [4:0]   rs1_q;
    logic [4:0]   rs2_q;
    logic [4:0]   rd_q;
    logic [31:0]  imm_q;
    logic [2:0]   funct3_q;
    logic         funct7b5_q;
    logic [31:0]  pc_q;
    logic         retire_q;
    logic         trap_q;
    logic         isBranch_q;
    logic         isBne_q;
    logic         branchTaken_q;

    logic [31:0]  decImm_d;
    instr_class_e decClass_d;
    logic [31:0]  pcNext_d;

    imm_gen u_immGen (
        .instr_i (instrWord_q),
        .imm_o   (decImm_d)
    );

    assign decClass_d = classify(instrWord_q);

    // Sequential PC advance: branch target when taken, else fall through; wraps mod 2^32.
    assign pcNext_d = pc_q + (branchTaken_q ? imm_q : 32'd4);

    // Sequencer FSM; every control output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instrWord_q   <= '0;
            ready_q       <= 1'b0;
            we_q          <= 1'b0;
            aluOp_q       <= ALUOP_ADD;
            aluSrc_q      <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            funct3_q      <= '0;
            funct7b5_q    <= 1'b0;
            pc_q          <= RESET_PC;
            retire_q      <= 1'b0;
            trap_q        <= 1'b0;
            isBranch_q    <= 1'b0;
            isBne_q       <= 1'b0;
            branchTaken_q <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (instr_valid && ready_q) begin
                        instrWord_q <= instr;
                        ready_q     <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rs1_q         <= instrWord_q[19:15];
                    rs2_q         <= instrWord_q[24:20];
                    rd_q          <= instrWord_q[11:7];
                    funct3_q      <= instrWord_q[14:12];
                    imm_q         <= decImm_d;
                    isBranch_q    <= (decClass_d == CLS_BRANCH);
                    isBne_q       <= instrWord_q[12];
                    branchTaken_q <= 1'b0;
                    case (decClass_d)
                        CLS_R: begin
                            aluOp_q    <= ALUOP_FUNCT;
                            aluSrc_q   <= 1'b0;
                            funct7b5_q <= instrWord_q[30];
                            we_q       <= (instrWord_q[11:7] != 5'd0);
                            state_q    <= ST_EXEC;
                        end
                        CLS_I: begin
                            aluOp_q    <= ALUOP_FUNCT;
                            aluSrc_q   <= 1'b1;
                            funct7b5_q <= (instrWord_q[14:12] == 3'b101) ? instrWord_q[30] : 1'b0;
                            we_q       <= (instrWord_q[11:7] != 5'd0);
                            state_q    <= ST_EXEC;
                        end
                        CLS_BRANCH: begin
                            aluOp_q    <= ALUOP_BR;
                            aluSrc_q   <= 1'b0;
                            funct7b5_q <= 1'b0;
                            we_q       <= 1'b0;
                            state_q    <= ST_EXEC;
                        end
                        default: begin
                            aluOp_q    <= ALUOP_ADD;
                            aluSrc_q   <= 1'b0;
                            funct7b5_q <= 1'b0;
                            we_q       <= 1'b0;
                            trap_q     <= 1'b1;
                            state_q    <= ST_TRAP;
                        end
                    endcase
                end
                ST_EXEC: begin
                    we_q          <= 1'b0;
                    aluOp_q       <= ALUOP_ADD;
                    aluSrc_q      <= 1'b0;
                    retire_q      <= 1'b1;
                    branchTaken_q <= isBranch_q && (isBne_q ? !zero : zero);
                    state_q       <= ST_RETIRE;
                end
                ST_RETIRE: begin
                    pc_q          <= pcNext_d;
                    branchTaken_q <= 1'b0;
                    ready_q       <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                ST_TRAP: begin
                    pc_q    <= pc_q + 32'd4;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign we          = we_q;
    assign alu_op      = aluOp_q;
    assign alu_src     = aluSrc_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign imm         = imm_q;
    assign funct3      = funct3_q;
    assign funct7_5    = funct7b5_q;
    assign pc          = pc_q;
    assign retire      = retire_q;
    assign trap        = trap_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycleCnt_q;
    logic [31:0] instretCnt_q;

    // Free-running cycle counter and retired-instruction counter; traps are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleCnt_q   <= '0;
            instretCnt_q <= '0;
        end else begin
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (state_q == ST_RETIRE) begin
                instretCnt_q <= instretCnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycleCnt_q;
    assign instret_cnt = instretCnt_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed self-checking bench for exec_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_exec_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        zero;
    logic        we;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic        retire;
    logic        trap;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Observations gathered by applyStimulus over the four cycles after acceptance.
    int          weCount, retireCount, trapCount, readyLow, retireCyc;
    logic        exWe, exAluSrc, exF7;
    logic [1:0]  exAluOp, rtAluOp;
    logic [4:0]  exRs1, exRs2, exRd;
    logic [2:0]  exF3;
    logic [31:0] exImm;
    logic        exTrap;

    exec_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .zero        (zero),
        .we          (we),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .pc          (pc),
        .retire      (retire),
        .trap        (trap)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for instr_ready; returns 1 when ready was seen.
    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one instruction, hold valid for holdCycles extra cycles, and record four cycles of outputs.
    task automatic applyStimulus(input logic [31:0] word, input logic zeroVal, input int holdCycles);
        bit ok;
        weCount = 0; retireCount = 0; trapCount = 0; readyLow = 0; retireCyc = 0;
        waitReady(ok);
        if (!ok) return;
        instr       = word;
        instr_valid = 1'b1;
        zero        = zeroVal;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            instr = 32'hFFFF_FFFF;
            if (cyc > holdCycles) instr_valid = 1'b0;
            weCount     += int'(we);
            retireCount += int'(retire);
            trapCount   += int'(trap);
            readyLow    += int'(!instr_ready);
            if (retire) retireCyc = cyc;
            if (cyc == 2) begin
                exWe = we; exAluOp = alu_op; exAluSrc = alu_src; exImm = imm;
                exRs1 = rs1; exRs2 = rs2; exRd = rd; exF3 = funct3; exF7 = funct7_5;
                exTrap = trap;
            end
            if (cyc == 3) rtAluOp = alu_op;
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; zero = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset checks");
        checkOutput("rst_ready",  {31'd0, instr_ready}, 32'd0);
        checkOutput("rst_pc",     pc, 32'h0);
        checkOutput("rst_we",     {31'd0, we}, 32'd0);
        checkOutput("rst_aluop",  {30'd0, alu_op}, 32'd0);
        checkOutput("rst_retire", {31'd0, retire}, 32'd0);
        checkOutput("rst_trap",   {31'd0, trap}, 32'd0);
`ifdef PERF_CNT_EN
        checkOutput("rst_cycle",   cycle_cnt, 32'd0);
        checkOutput("rst_instret", instret_cnt, 32'd0);
`endif
        rst_n = 1'b1;

        // addi x1,x0,5
        applyStimulus(32'h0050_0093, 1'b0, 0);
        checkOutput("addi_we",     {31'd0, exWe}, 32'd1);
        checkOutput("addi_src",    {31'd0, exAluSrc}, 32'd1);
        checkOutput("addi_imm",    exImm, 32'd5);
        checkOutput("addi_rd",     {27'd0, exRd}, 32'd1);
        checkOutput("addi_rs1",    {27'd0, exRs1}, 32'd0);
        checkOutput("addi_aluop",  {30'd0, exAluOp}, 32'd2);
        checkOutput("addi_retcyc", retireCyc, 32'd3);
        checkOutput("addi_ret_aluop", {30'd0, rtAluOp}, 32'd0);
        checkOutput("addi_pc",     pc, 32'd4);

        // add x3,x1,x2 with valid held three extra cycles
        applyStimulus(32'h0020_81B3, 1'b0, 3);
        checkOutput("add_wecnt",   weCount, 32'd1);
        checkOutput("add_rdylow",  readyLow, 32'd3);
        checkOutput("add_retcnt",  retireCount, 32'd1);
        checkOutput("add_src",     {31'd0, exAluSrc}, 32'd0);
        checkOutput("add_rs1",     {27'd0, exRs1}, 32'd1);
        checkOutput("add_rs2",     {27'd0, exRs2}, 32'd2);
        checkOutput("add_rd",      {27'd0, exRd}, 32'd3);
        checkOutput("add_pc",      pc, 32'd8);

        // beq x1,x1,-8 taken
        applyStimulus(32'hFE10_8CE3, 1'b1, 0);
        checkOutput("beq_aluop",   {30'd0, exAluOp}, 32'd1);
        checkOutput("beq_imm",     exImm, 32'hFFFF_FFF8);
        checkOutput("beq_wecnt",   weCount, 32'd0);
        checkOutput("beq_t_pc",    pc, 32'd0);

        // addi x0,x0,7: write to x0 suppressed
        applyStimulus(32'h0070_0013, 1'b0, 0);
        checkOutput("addix0_wecnt", weCount, 32'd0);
        checkOutput("addix0_ret",   retireCount, 32'd1);
        checkOutput("addix0_pc",    pc, 32'd4);

        // srai x5,x6,3
        applyStimulus(32'h4033_5293, 1'b0, 0);
        checkOutput("srai_f7",     {31'd0, exF7}, 32'd1);
        checkOutput("srai_f3",     {29'd0, exF3}, 32'd5);
        checkOutput("srai_imm",    exImm, 32'h0000_0403);
        checkOutput("srai_pc",     pc, 32'd8);

        // beq x1,x1,-8 not taken
        applyStimulus(32'hFE10_8CE3, 1'b0, 0);
        checkOutput("beq_nt_pc",   pc, 32'd12);

        // slli x5,x6,3
        applyStimulus(32'h0033_1293, 1'b0, 0);
        checkOutput("slli_f7",     {31'd0, exF7}, 32'd0);
        checkOutput("slli_pc",     pc, 32'd16);

        // addi x2,x0,-1024: instr[30]=1 but funct3 != 101
        applyStimulus(32'hC000_0113, 1'b0, 0);
        checkOutput("addineg_f7",  {31'd0, exF7}, 32'd0);
        checkOutput("addineg_imm", exImm, 32'hFFFF_FC00);
        checkOutput("addineg_pc",  pc, 32'd20);

        // bne x1,x2,+16: zero=0 taken, then zero=1 not taken
        applyStimulus(32'h0020_9863, 1'b0, 0);
        checkOutput("bne_t_pc",    pc, 32'd36);
        applyStimulus(32'h0020_9863, 1'b1, 0);
        checkOutput("bne_nt_pc",   pc, 32'd40);

        // Illegal opcode and unsupported branch funct3
        applyStimulus(32'h0000_007F, 1'b0, 0);
        checkOutput("ill_trap",    trapCount, 32'd1);
        checkOutput("ill_trap_cyc", {31'd0, exTrap}, 32'd1);
        checkOutput("ill_wecnt",   weCount, 32'd0);
        checkOutput("ill_retcnt",  retireCount, 32'd0);
        checkOutput("ill_pc",      pc, 32'd44);
        applyStimulus(32'h0000_2063, 1'b0, 0);
        checkOutput("illbr_trap",  trapCount, 32'd1);
        checkOutput("illbr_pc",    pc, 32'd48);

        // Wrap: beq x0,x0,-64 from 48, then beq +16 across 2^32
        applyStimulus(32'hFC00_00E3, 1'b1, 0);
        checkOutput("wrap_neg_pc", pc, 32'hFFFF_FFF0);
        applyStimulus(32'h0000_0863, 1'b1, 0);
        checkOutput("wrap_pos_pc", pc, 32'h0000_0000);
`ifdef PERF_CNT_EN
        checkOutput("instret_seq", instret_cnt, 32'd12);
`endif

        // Reset during EXEC of addi x7,x0,1
        waitReady(ok);
        if (ok) begin
            instr = 32'h0010_0393; instr_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            instr_valid = 1'b0;
            @(negedge clk);
            checkOutput("abort_we_exec", {31'd0, we}, 32'd1);
            #1 rst_n = 1'b0;
            #1;
            checkOutput("abort_we",    {31'd0, we}, 32'd0);
            checkOutput("abort_pc",    pc, 32'h0);
            checkOutput("abort_ready", {31'd0, instr_ready}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            checkOutput("abort_noret", {31'd0, retire}, 32'd0);
        end
        applyStimulus(32'h0000_007F, 1'b0, 0);
        applyStimulus(32'h0050_0093, 1'b0, 0);
        checkOutput("post_rst_pc", pc, 32'd8);
`ifdef PERF_CNT_EN
        checkOutput("instret_post", instret_cnt, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
